// File: rtl/blake2_pkg.sv
// blake2 shared definitions: controller state encoding, block geometry,
// configuration limits and the IV / message schedule constants of the core.
package blake2_pkg;

    localparam int BLK_BYTES = 64;
    localparam int IDX_W     = 6;
    localparam int MAX_KN    = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_MSG,
        S_PAD,
        S_WAIT_RES,
        S_RES
    } state_t;

    // IV word i sits at bits [32*i +: 32]
    localparam logic [255:0] IV = {
        32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
        32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667
    };

    // row r at bits [64*r +: 64], element i of a row at nibble i
    localparam logic [639:0] SIGMA = {
        64'h0DC3E9BF5167482A, 64'h5A417D2C803B9EF6,
        64'hA2684F05931CE7BD, 64'hB8293670A4DEF15C,
        64'h91EF57D438B0A6C2, 64'hD386CB1EFA427509,
        64'h8F04A562EBCD1397, 64'h491763EADF250C8B,
        64'h357B20C16DF984AE, 64'hFEDCBA9876543210
    };

    function automatic logic [3:0] sigma(input int r, input int i);
        return SIGMA[64*r + 4*i +: 4];
    endfunction

endpackage

// File: rtl/blake2_res_filter.sv
// blake2 result filter: drops the stale early beat handling in the top,
// counts forwarded digest bytes and flags the nn-th one.
module blake2_res_filter
    import blake2_pkg::*;
#(
    parameter int KK_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_i,
    input  logic            pass_i,
    input  logic [KK_W-1:0] nn_i,
    input  logic            h_v_i,
    input  logic [7:0]      h_i,
    output logic            res_v_o,
    output logic [7:0]      res_o,
    output logic            res_last_o,
    output logic            done_o
);

    logic [KK_W-1:0] cnt;
    logic            hit;

    assign hit    = pass_i & h_v_i;
    assign done_o = hit & (cnt == nn_i - 1'b1);

    // register digest bytes and track how many have gone out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            res_v_o    <= 1'b0;
            res_o      <= '0;
            res_last_o <= 1'b0;
        end else begin
            res_v_o    <= hit;
            res_o      <= hit ? h_i : 8'h00;
            res_last_o <= done_o;
            if (clr_i)
                cnt <= '0;
            else if (hit)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/blake2_stream_ctrl.sv
// blake2 front-end: cuts key+message stream into zero-padded 64-byte blocks
// for the core and turns the core result stream into a clean digest.
module blake2_stream_ctrl
    import blake2_pkg::*;
#(
    parameter int LL_W      = 64,
    parameter int CORE_LL_W = 128,
    parameter int KK_W      = 6,
    parameter int BLK_BYTES_P = BLK_BYTES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [KK_W-1:0]      kk_i,
    input  logic [KK_W-1:0]      nn_i,
    input  logic [LL_W-1:0]      ll_i,
    output logic                 busy_o,
    output logic                 cfg_err_o,
    input  logic                 s_valid_i,
    input  logic [7:0]           s_data_i,
    output logic                 s_ready_o,
    output logic [KK_W-1:0]      core_kk_o,
    output logic [KK_W-1:0]      core_nn_o,
    output logic [CORE_LL_W-1:0] core_ll_o,
    output logic                 core_data_v_o,
    output logic [IDX_W-1:0]     core_data_idx_o,
    output logic [7:0]           core_data_o,
    output logic                 core_block_first_o,
    output logic                 core_block_last_o,
    input  logic                 core_ready_i,
    input  logic                 core_h_v_i,
    input  logic [7:0]           core_h_i,
    output logic                 res_v_o,
    output logic [7:0]           res_o,
    output logic                 res_last_o
);

    // block counts reach ceil(2^LL_W/64)+1
    localparam int BT_W = LL_W - IDX_W + 1;
    localparam logic [KK_W-1:0] KN_MAX = KK_W'(MAX_KN);

    state_t                state, state_nx;
    logic [KK_W-1:0]       key_cnt;
    logic [LL_W-1:0]       rem;
    logic [IDX_W-1:0]      idx;
    logic                  first, last;
    logic [BT_W-1:0]       blk_cnt, blk_tot;
    logic                  cfg_bad, accept, issue;
    logic [CORE_LL_W-1:0]  ll_sum;
    logic [BT_W-1:0]       tot_raw, tot;
    logic                  res_done;

    assign cfg_bad = (nn_i == '0) | (nn_i > KN_MAX) | (kk_i > KN_MAX);
    assign accept  = (state == S_IDLE) & start_i & ~cfg_bad;

    assign ll_sum  = CORE_LL_W'(ll_i)
                   + ((kk_i != '0) ? CORE_LL_W'(BLK_BYTES_P) : '0);
    assign tot_raw = BT_W'(ll_i[LL_W-1:IDX_W])
                   + BT_W'(|ll_i[IDX_W-1:0])
                   + BT_W'(kk_i != '0);
    assign tot     = (tot_raw == '0) ? BT_W'(1) : tot_raw;

    assign busy_o             = (state != S_IDLE);
    assign core_data_idx_o    = idx;
    assign core_block_first_o = first;
    assign core_block_last_o  = last;
    assign core_data_v_o      = issue;

    // next state and byte issue towards the core
    always_comb begin
        state_nx    = state;
        issue       = 1'b0;
        core_data_o = 8'h00;
        s_ready_o   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (kk_i != '0)
                        state_nx = S_KEY;
                    else if (ll_i != '0)
                        state_nx = S_MSG;
                    else
                        state_nx = S_PAD;
                end
            end
            S_KEY: begin
                s_ready_o = core_ready_i;
                issue     = core_ready_i & s_valid_i;
                if (issue) begin
                    core_data_o = s_data_i;
                    if (key_cnt == core_kk_o - 1'b1)
                        state_nx = S_PAD;
                end
            end
            S_MSG: begin
                s_ready_o = core_ready_i;
                issue     = core_ready_i & s_valid_i;
                if (issue) begin
                    core_data_o = s_data_i;
                    if (rem == LL_W'(1))
                        state_nx = (idx == '1) ? S_WAIT_RES : S_PAD;
                end
            end
            S_PAD: begin
                issue = core_ready_i;
                if (issue && idx == '1)
                    state_nx = last ? S_WAIT_RES : S_MSG;
            end
            S_WAIT_RES: begin
                if (core_h_v_i)
                    state_nx = S_RES;
            end
            S_RES: begin
                if (res_done)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // state, configuration latch and block/byte bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cfg_err_o <= 1'b0;
            core_kk_o <= '0;
            core_nn_o <= '0;
            core_ll_o <= '0;
            key_cnt   <= '0;
            rem       <= '0;
            idx       <= '0;
            first     <= 1'b0;
            last      <= 1'b0;
            blk_cnt   <= '0;
            blk_tot   <= '0;
        end else begin
            state     <= state_nx;
            cfg_err_o <= (state == S_IDLE) & start_i & cfg_bad;
            if (accept) begin
                core_kk_o <= kk_i;
                core_nn_o <= nn_i;
                core_ll_o <= ll_sum;
                key_cnt   <= '0;
                rem       <= ll_i;
                idx       <= '0;
                first     <= 1'b1;
                last      <= (tot == BT_W'(1));
                blk_cnt   <= '0;
                blk_tot   <= tot;
            end else if (issue) begin
                idx <= idx + 1'b1;
                if (state == S_KEY)
                    key_cnt <= key_cnt + 1'b1;
                if (state == S_MSG)
                    rem <= rem - 1'b1;
                if (idx == '1) begin
                    first   <= 1'b0;
                    blk_cnt <= blk_cnt + 1'b1;
                    last    <= ((blk_cnt + 1'b1) == (blk_tot - 1'b1));
                end
            end
        end
    end

    blake2_res_filter #(
        .KK_W(KK_W)
    ) u_res_filter (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state == S_WAIT_RES),
        .pass_i    (state == S_RES),
        .nn_i      (core_nn_o),
        .h_v_i     (core_h_v_i),
        .h_i       (core_h_i),
        .res_v_o   (res_v_o),
        .res_o     (res_o),
        .res_last_o(res_last_o),
        .done_o    (res_done)
    );

endmodule

// File: tb/tb_blake2_stream_ctrl.sv
// Bench for blake2_stream_ctrl: mock core, queue scoreboard of expected
// core beats and digest bytes, directed job sequence.
module tb_blake2_stream_ctrl;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start_i = 1'b0;
    logic [5:0]   kk_i = '0;
    logic [5:0]   nn_i = '0;
    logic [63:0]  ll_i = '0;
    logic         busy_o, cfg_err_o;
    logic         s_valid_i = 1'b0;
    logic [7:0]   s_data_i = '0;
    logic         s_ready_o;
    logic [5:0]   core_kk_o, core_nn_o;
    logic [127:0] core_ll_o;
    logic         core_data_v_o;
    logic [5:0]   core_data_idx_o;
    logic [7:0]   core_data_o;
    logic         core_block_first_o, core_block_last_o;
    logic         core_ready_i = 1'b1;
    logic         core_h_v_i = 1'b0;
    logic [7:0]   core_h_i = '0;
    logic         res_v_o;
    logic [7:0]   res_o;
    logic         res_last_o;

    always #5 clk = ~clk;

    blake2_stream_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .start_i           (start_i),
        .kk_i              (kk_i),
        .nn_i              (nn_i),
        .ll_i              (ll_i),
        .busy_o            (busy_o),
        .cfg_err_o         (cfg_err_o),
        .s_valid_i         (s_valid_i),
        .s_data_i          (s_data_i),
        .s_ready_o         (s_ready_o),
        .core_kk_o         (core_kk_o),
        .core_nn_o         (core_nn_o),
        .core_ll_o         (core_ll_o),
        .core_data_v_o     (core_data_v_o),
        .core_data_idx_o   (core_data_idx_o),
        .core_data_o       (core_data_o),
        .core_block_first_o(core_block_first_o),
        .core_block_last_o (core_block_last_o),
        .core_ready_i      (core_ready_i),
        .core_h_v_i        (core_h_v_i),
        .core_h_i          (core_h_i),
        .res_v_o           (res_v_o),
        .res_o             (res_o),
        .res_last_o        (res_last_o)
    );

    typedef struct packed {
        logic [5:0] idx;
        logic [7:0] d;
        logic       f;
        logic       l;
    } beat_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } rbeat_t;

    beat_t        exp_core[$];
    rbeat_t       exp_res[$];
    logic [7:0]   src[$];
    logic [7:0]   dig[32];
    logic [255:0] abc_dig;
    int           n_asrt = 0;
    int           n_fail = 0;
    logic         pend_blk = 1'b0;
    logic         pend_last = 1'b0;
    logic         mock_busy = 1'b0;
    logic         sready_seen = 1'b0;
    int           stall = 0;
    int           rphase = 0;
    beat_t        gb, eb;
    rbeat_t       gr, er;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: compare every core beat and digest byte as it appears
    always @(negedge clk) begin
        if (!reset) begin
            if (s_ready_o)
                sready_seen = 1'b1;
            if (core_data_v_o) begin
                gb.idx = core_data_idx_o;
                gb.d   = core_data_o;
                gb.f   = core_block_first_o;
                gb.l   = core_block_last_o;
                chk("core_beat_expected", exp_core.size() != 0, 1);
                if (exp_core.size() != 0) begin
                    eb = exp_core.pop_front();
                    chk("core_beat", gb, eb);
                end
                if (gb.idx == 6'd63) begin
                    if (gb.l)
                        pend_last = 1'b1;
                    else
                        pend_blk = 1'b1;
                end
            end
            if (res_v_o) begin
                gr.d = res_o;
                gr.l = res_last_o;
                chk("res_beat_expected", exp_res.size() != 0, 1);
                if (exp_res.size() != 0) begin
                    er = exp_res.pop_front();
                    chk("res_beat", gr, er);
                end
            end
        end
    end

    // mock core: ready stall per block, stale early beat then 32 bytes
    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            core_ready_i = 1'b1;
            core_h_v_i   = 1'b0;
            core_h_i     = '0;
            stall        = 0;
            rphase       = 0;
            mock_busy    = 1'b0;
            pend_blk     = 1'b0;
            pend_last    = 1'b0;
        end else begin
            core_h_v_i = 1'b0;
            core_h_i   = '0;
            if (pend_blk) begin
                pend_blk     = 1'b0;
                core_ready_i = 1'b0;
                stall        = 3;
            end else if (stall > 0) begin
                stall--;
                if (stall == 0)
                    core_ready_i = 1'b1;
            end
            if (pend_last) begin
                pend_last    = 1'b0;
                core_ready_i = 1'b0;
                mock_busy    = 1'b1;
                rphase       = 1;
            end else if (rphase > 0) begin
                rphase++;
                if (rphase >= 5 && rphase <= 37) begin
                    core_h_v_i = 1'b1;
                    core_h_i   = (rphase == 5) ? 8'hEE : dig[rphase-6];
                end
                if (rphase == 38) begin
                    rphase       = 0;
                    mock_busy    = 1'b0;
                    core_ready_i = 1'b1;
                end
            end
        end
    end

    task automatic build_exp(input int kk, input int nn, input int ll);
        beat_t b;
        rbeat_t r;
        int nm;
        nm = (ll + 63) / 64;
        if (kk == 0 && ll == 0)
            nm = 1;
        if (kk != 0) begin
            for (int i = 0; i < 64; i++) begin
                b.idx = 6'(i);
                b.d   = (i < kk) ? src[i] : 8'h00;
                b.f   = 1'b1;
                b.l   = (nm == 0);
                exp_core.push_back(b);
            end
        end
        for (int k = 0; k < nm; k++) begin
            for (int i = 0; i < 64; i++) begin
                b.idx = 6'(i);
                b.d   = (k*64 + i < ll) ? src[kk + k*64 + i] : 8'h00;
                b.f   = (kk == 0 && k == 0);
                b.l   = (k == nm - 1);
                exp_core.push_back(b);
            end
        end
        for (int i = 0; i < nn; i++) begin
            r.d = dig[i];
            r.l = (i == nn - 1);
            exp_res.push_back(r);
        end
    endtask

    task automatic rand_src(input int n);
        src.delete();
        for (int i = 0; i < n; i++)
            src.push_back(8'($urandom));
    endtask

    task automatic rand_dig();
        for (int i = 0; i < 32; i++)
            dig[i] = 8'($urandom);
    endtask

    task automatic start_job(input int kk, input int nn, input int ll);
        kk_i    = 6'(kk);
        nn_i    = 6'(nn);
        ll_i    = 64'(ll);
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic feed(input int n, input bit tog);
        int to;
        for (int i = 0; i < n; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = src.pop_front();
            to = 0;
            @(negedge clk);
            while (!s_ready_o && to < 300) begin
                to++;
                @(negedge clk);
            end
            if (to >= 300)
                chk("src_handshake_timeout", to, 0);
            @(posedge clk);
            #1;
            if (tog) begin
                s_valid_i = 1'b0;
                s_data_i  = '0;
                @(posedge clk);
                #1;
            end
        end
        s_valid_i = 1'b0;
        s_data_i  = '0;
    endtask

    task automatic wait_done();
        int to;
        to = 0;
        while ((busy_o || mock_busy || exp_res.size() != 0) && to < 3000) begin
            @(posedge clk);
            #1;
            to++;
        end
        if (to >= 3000)
            chk("job_done_timeout", to, 0);
        chk("core_queue_drained", exp_core.size(), 0);
        chk("res_queue_drained", exp_res.size(), 0);
        chk("busy_after_job", busy_o, 0);
    endtask

    task automatic load_abc();
        src.delete();
        src.push_back(8'h61);
        src.push_back(8'h62);
        src.push_back(8'h63);
        abc_dig = 256'h508c5e8c327c14e2e1a72ba34eeb452f37458b209ed63a294d999b4c86675982;
        for (int i = 0; i < 32; i++)
            dig[i] = abc_dig[255 - 8*i -: 8];
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_s_ready", s_ready_o, 0);
        chk("rst_core_v", core_data_v_o, 0);
        chk("rst_core_ll", core_ll_o, 0);
        chk("rst_core_kk", core_kk_o, 0);
        chk("rst_core_nn", core_nn_o, 0);
        chk("rst_res_v", res_v_o, 0);
        chk("rst_cfg_err", cfg_err_o, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // "abc", no key
        load_abc();
        build_exp(0, 32, 3);
        start_job(0, 32, 3);
        chk("abc_busy", busy_o, 1);
        chk("abc_core_ll", core_ll_o, 3);
        chk("abc_core_nn", core_nn_o, 32);
        feed(3, 0);
        wait_done();

        // empty message: one zero block, no source traffic
        rand_dig();
        src.delete();
        build_exp(0, 32, 0);
        sready_seen = 1'b0;
        start_job(0, 32, 0);
        chk("empty_core_ll", core_ll_o, 0);
        wait_done();
        chk("empty_no_s_ready", sready_seen, 0);

        // exactly one full block
        rand_dig();
        rand_src(64);
        build_exp(0, 16, 64);
        start_job(0, 16, 64);
        chk("ll64_core_ll", core_ll_o, 64);
        feed(64, 0);
        wait_done();

        // one byte into a second block
        rand_dig();
        rand_src(65);
        build_exp(0, 20, 65);
        start_job(0, 20, 65);
        chk("ll65_core_ll", core_ll_o, 65);
        feed(65, 0);
        wait_done();

        // 32-byte key then 3 message bytes
        rand_dig();
        rand_src(35);
        build_exp(32, 32, 3);
        start_job(32, 32, 3);
        chk("key_core_ll", core_ll_o, 67);
        chk("key_core_kk", core_kk_o, 32);
        feed(35, 0);
        wait_done();

        // toggled source valid, plus a start attempt while busy
        rand_dig();
        rand_src(45);
        build_exp(5, 8, 40);
        start_job(5, 8, 40);
        start_job(1, 0, 7);
        @(negedge clk);
        chk("busy_start_no_err", cfg_err_o, 0);
        chk("busy_start_kk_held", core_kk_o, 5);
        chk("busy_start_nn_held", core_nn_o, 8);
        chk("busy_start_ll_held", core_ll_o, 104);
        @(posedge clk);
        #1;
        feed(45, 1);
        wait_done();

        // rejected configurations
        start_job(0, 0, 10);
        @(negedge clk);
        chk("nn0_cfg_err", cfg_err_o, 1);
        chk("nn0_not_busy", busy_o, 0);
        @(negedge clk);
        chk("nn0_cfg_err_pulse", cfg_err_o, 0);
        @(posedge clk);
        #1;
        start_job(33, 16, 10);
        @(negedge clk);
        chk("kk33_cfg_err", cfg_err_o, 1);
        chk("kk33_not_busy", busy_o, 0);
        @(posedge clk);
        #1;

        // abort in the message phase at byte 20
        rand_dig();
        rand_src(100);
        build_exp(0, 32, 100);
        start_job(0, 32, 100);
        feed(20, 0);
        @(negedge clk);
        chk("abort_idx_before", core_data_idx_o, 20);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", busy_o, 0);
        chk("abort_s_ready", s_ready_o, 0);
        chk("abort_core_v", core_data_v_o, 0);
        chk("abort_idx", core_data_idx_o, 0);
        chk("abort_first", core_block_first_o, 0);
        chk("abort_core_ll", core_ll_o, 0);
        chk("abort_core_kk", core_kk_o, 0);
        chk("abort_core_nn", core_nn_o, 0);
        exp_core.delete();
        exp_res.delete();
        src.delete();
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // fresh hash after the abort
        load_abc();
        build_exp(0, 32, 3);
        start_job(0, 32, 3);
        chk("post_abort_core_ll", core_ll_o, 3);
        feed(3, 0);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/blake2_stream_ctrl.md
Name: blake2_stream_ctrl

Overview:
Front-end sequencer for the blake2 hash core. It takes a configuration (key length, digest length, message length) and a byte stream carrying the optional key followed by the message. It cuts the stream into 64-byte blocks, zero-pads the key block and the final block, and drives the core's indexed byte interface with first/last flags and the adjusted length. It then filters the core's early-asserted result stream into a clean nn-byte digest stream with a last marker.

Parameters:
LL_W, 64, width of the message byte length input
CORE_LL_W, 128, width of the core length port
KK_W, 6, width of the key/digest length fields (matches core)
BLK_BYTES, 64, bytes per compression block (fixed; idx width 6)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start_i  in  1  start pulse; config sampled in IDLE only
kk_i  in  KK_W  key length in bytes, 0..32
nn_i  in  KK_W  digest length in bytes, 1..32
ll_i  in  LL_W  message length in bytes (key excluded)
busy_o  out  1  high from accepted start until last digest byte
cfg_err_o  out  1  one-cycle pulse when start is rejected
s_valid_i  in  1  source byte valid
s_data_i  in  8  source byte (key bytes first, then message)
s_ready_o  out  1  source byte accepted when valid&ready
core_kk_o  out  KK_W  registered kk to core
core_nn_o  out  KK_W  registered nn to core
core_ll_o  out  CORE_LL_W  length to core
core_data_v_o  out  1  byte strobe to core
core_data_idx_o  out  6  byte index in block
core_data_o  out  8  byte to core
core_block_first_o  out  1  current block is first
core_block_last_o  out  1  current block is last
core_ready_i  in  1  core ready_v
core_h_v_i  in  1  core result valid
core_h_i  in  8  core result byte
res_v_o  out  1  digest byte valid (no backpressure)
res_o  out  8  digest byte
res_last_o  out  1  marks the nn-th digest byte

Behaviour:
- Reset (async) drives state IDLE and clears all counters. Every output is 0 after reset, including core_kk_o, core_nn_o and core_ll_o.
- States: IDLE, KEY, MSG, PAD, WAIT_RES, RES.
- IDLE + start_i:
  - Reject if nn_i==0, nn_i>32 or kk_i>32: pulse cfg_err_o and stay in IDLE.
  - Otherwise latch kk/nn and set core_ll_o = ll_i + (kk!=0 ? 64 : 0), zero-extended.
  - Set rem = ll_i, byte_idx = 0, first = 1.
  - blocks_total = (kk!=0) + ceil(ll/64), minimum 1.
  - Next state: KEY if kk!=0; MSG if ll!=0; else PAD (a single all-zero block).
- start_i outside IDLE is ignored, with no error pulse.
- Byte issue: at most one core byte per cycle, only when core_ready_i=1.
  - core_data_idx_o = byte_idx. byte_idx increments per issued byte and wraps 63→0.
  - core_block_first_o / core_block_last_o are constant across all 64 bytes of a block.
- KEY: s_ready_o = core_ready_i. Each handshake forwards one byte. After kk key bytes, go to PAD for the remaining 64-kk bytes (data 0, no source handshake).
- MSG: s_ready_o = core_ready_i. Each handshake forwards a byte and decrements rem.
  - When rem hits 0 with byte_idx≠63: go to PAD.
  - When rem hits 0 with byte_idx==63: go to WAIT_RES.
- PAD: s_ready_o = 0; issue zero bytes. At byte_idx 63: go to WAIT_RES if this was the last block, else MSG.
- Block boundary (byte 63 issued): clear first, increment the block counter. last = (block counter == blocks_total-1).
- A source stall (s_valid_i=0) issues no core byte and holds byte_idx. Core bytes are never emitted with a gap in idx.
- The core deasserts ready for compression; the controller simply waits.
- Result path: the core asserts h_v one beat early, and that first beat carries stale data.
  - WAIT_RES: on the first core_h_v_i, discard the beat and go to RES.
  - RES: forward core_h_i / core_h_v_i registered, 1-cycle latency, as res_o / res_v_o.
  - Count beats; res_last_o is high on beat nn. Then go to IDLE and drop busy_o in the same cycle.
- core_kk_o, core_nn_o and core_ll_o are held stable from start until IDLE is re-entered.
- Reset mid-operation aborts immediately. The core must be reset with it (system-level).

Decomposition:
- Package blake2_pkg: state encoding, BLK_BYTES, the max kk/nn constant (32), IV/sigma constants shared with the core.
- One natural sub-module: blake2_res_filter (discard-first-beat, nn counter, last marker).
- The block sequencer stays in the top.

Test Plan:
- kk=0, nn=32, ll=3, bytes "abc" -> 64 core beats: 3 data + 61 zeros, first=last=1, core_ll_o=3. Digest = 508c5e8c327c14e2e1a72ba34eeb452f37458b209ed63a294d999b4c86675982, res_last_o on byte 32.
- kk=0, ll=0, nn=32 -> exactly 64 zero bytes, first=last=1, core_ll_o=0, s_ready_o never high.
- ll=64 -> one block with no pad. ll=65 -> two blocks: block 0 first-only; block 1 last-only with 1 data + 63 zeros; core_ll_o=65.
- kk=32, ll=3 -> block 0 = 32 key + 32 zeros (first=1, last=0); block 1 = 3 data + 61 zeros (last=1); core_ll_o=67.
- s_valid_i toggled 1/0 every cycle mid-block -> idx contiguous, no core_data_v on stall cycles. start_i during busy ignored. nn=0 -> cfg_err_o pulse.
- Assert reset in MSG at byte 20 -> all outputs 0 asynchronously, state IDLE; a following start produces a correct fresh hash.
